// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver.
package seg_pkg;

  typedef enum logic [1:0] {OFF, BLANK, SHOW} state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Counter width able to hold n-1; at least one bit so n=1 still elaborates.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// Hex nibble to active-low segments {g,f,e,d,c,b,a}; purely combinational.
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with an
// all-anodes-off gap between digits to suppress ghosting.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIV_COUNT    = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] hex_in,
  input  logic [7:0] blank_mask,
  input  logic [7:0] dp_mask,
  output logic [2:0] select,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int DW = cnt_w(DIV_COUNT);
  localparam int BW = cnt_w(BLANK_CYCLES);
  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV_COUNT - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  state_t          state, state_nx;
  logic [DW-1:0]   div_cnt, div_cnt_nx;
  logic [BW-1:0]   blk_cnt, blk_cnt_nx;
  logic [2:0]      sel_nx;
  logic [7:0]      an_nx;
  logic [6:0]      seg_nx, dec;
  logic            dp_nx, fs_nx;
  logic            blank_done, show_done;

  hex7seg_decode u_dec (.nibble(hex_in), .seg(dec));

  assign blank_done = (state == BLANK) && (blk_cnt == BLANK_LAST);
  assign show_done  = (state == SHOW)  && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= OFF;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!enable) state_nx = OFF;
    else begin
      case (state)
        OFF:     state_nx = BLANK;
        BLANK:   if (blank_done) state_nx = SHOW;
        SHOW:    if (show_done)  state_nx = BLANK;
        default: state_nx = OFF;
      endcase
    end
  end

  // Next-value logic for the registered outputs and counters.
  // Disable wins over every counter event.
  always_comb begin
    sel_nx     = select;
    an_nx      = an;
    seg_nx     = seg;
    dp_nx      = dp;
    fs_nx      = 1'b0;
    blk_cnt_nx = blk_cnt;
    div_cnt_nx = div_cnt;
    if (!enable || state == OFF) begin
      sel_nx     = 3'd0;
      an_nx      = AN_OFF;
      seg_nx     = SEG_OFF;
      dp_nx      = 1'b1;
      blk_cnt_nx = '0;
      div_cnt_nx = '0;
    end else begin
      case (state)
        BLANK: begin
          if (blank_done) begin
            seg_nx     = dec;
            dp_nx      = ~dp_mask[select];
            an_nx      = blank_mask[select] ? AN_OFF : ~(8'b1 << select);
            fs_nx      = (select == 3'd0);
            blk_cnt_nx = '0;
            div_cnt_nx = '0;
          end else begin
            blk_cnt_nx = blk_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (show_done) begin
            an_nx      = AN_OFF;
            sel_nx     = select + 3'd1;
            div_cnt_nx = '0;
          end else begin
            div_cnt_nx = div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      select      <= 3'd0;
      an          <= AN_OFF;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
      blk_cnt     <= '0;
      div_cnt     <= '0;
    end else begin
      select      <= sel_nx;
      an          <= an_nx;
      seg         <= seg_nx;
      dp          <= dp_nx;
      frame_start <= fs_nx;
      blk_cnt     <= blk_cnt_nx;
      div_cnt     <= div_cnt_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a slicer feeds hex_in from a 32-bit word and a
// time-position model predicts every output each cycle.
module tb_seg_scan_driver;

  localparam int D     = 4;
  localparam int B     = 2;
  localparam int SLOT  = D + B;
  localparam int FRAME = 8 * SLOT;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic [3:0] hex_in;
  logic [7:0] blank_mask, dp_mask;
  logic [2:0] select;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp, frame_start;
  logic [31:0] word;

  always #5 clk = ~clk;

  assign hex_in = word[{select, 2'b00} +: 4];

  seg_scan_driver #(.DIV_COUNT(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .enable(enable), .hex_in(hex_in),
    .blank_mask(blank_mask), .dp_mask(dp_mask), .select(select),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] dec_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: m_p counts edges since enable was sampled; position within the
  // frame tells which digit is active and whether it is in its gap or lit.
  bit         m_on;
  int         m_p;
  logic [7:0] m_an;
  logic [6:0] m_seg;
  logic       m_dp, m_fs;
  logic [2:0] m_sel;

  task automatic m_off();
    m_on = 0; m_p = 0; m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1; m_sel = 3'd0; m_fs = 1'b0;
  endtask

  task automatic m_edge();
    int q, dg, r;
    m_fs = 1'b0;
    if (!enable) m_off();
    else if (!m_on) begin m_off(); m_on = 1; end
    else begin
      m_p++;
      q = m_p % FRAME; dg = q / SLOT; r = q % SLOT;
      if (r == 0) begin
        m_an = 8'hFF; m_sel = 3'(dg);
      end else if (r == B) begin
        m_seg = dec_tab[word[dg*4 +: 4]];
        m_dp  = ~dp_mask[dg];
        m_an  = blank_mask[dg] ? 8'hFF : ~(8'd1 << dg);
        m_fs  = (dg == 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; blank_mask = 0; dp_mask = 0; word = 32'h1AE5BCE3;
    m_off();
    #12;
    @(negedge clk); reset = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp, select, frame_start} !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got an=%h seg=%b dp=%b sel=%0d fs=%b want an=ff seg=1111111 dp=1 sel=0 fs=0",
                 i, an, seg, dp, select, frame_start);
      end
    end
  endtask

  task automatic test_first_digit();
    enable = 1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp, select, frame_start} !== {m_an, m_seg, m_dp, m_sel, m_fs}) begin
        n_bad++;
        $display("FAIL first_digit edge=%0d got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b",
                 i, an, seg, dp, select, frame_start, m_an, m_seg, m_dp, m_sel, m_fs);
      end
      if (i == 3) begin
        n_cmp++;
        if ({an, seg, frame_start} !== {8'hFE, 7'b0110000, 1'b1}) begin
          n_bad++;
          $display("FAIL first_lit got an=%h seg=%b fs=%b want an=fe seg=0110000 fs=1", an, seg, frame_start);
        end
      end
      if (i == 6 || i == 7 || i == 9) begin
        n_cmp++;
        if (an !== (i == 6 ? 8'hFE : i == 7 ? 8'hFF : 8'hFD) || (i == 9 && seg !== 7'b0000110)) begin
          n_bad++;
          $display("FAIL digit_timing edge=%0d got an=%h seg=%b", i, an, seg);
        end
      end
    end
  endtask

  task automatic test_frames();
    int last_fs, n_fs;
    last_fs = -1; n_fs = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp, select, frame_start} !== {m_an, m_seg, m_dp, m_sel, m_fs}) begin
        n_bad++;
        $display("FAIL frames cyc=%0d got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b",
                 c, an, seg, dp, select, frame_start, m_an, m_seg, m_dp, m_sel, m_fs);
      end
      n_cmp++;
      if ($countones(~an) > 1) begin
        n_bad++;
        $display("FAIL one_anode cyc=%0d got an=%h want at most one low", c, an);
      end
      if (frame_start === 1'b1) begin
        n_fs++;
        if (last_fs >= 0) begin
          n_cmp++;
          if (c - last_fs != FRAME) begin
            n_bad++;
            $display("FAIL frame_period got %0d want %0d", c - last_fs, FRAME);
          end
        end
        last_fs = c;
      end
    end
    n_cmp++;
    if (n_fs != 2) begin
      n_bad++;
      $display("FAIL frame_count got %0d want 2", n_fs);
    end
  endtask

  task automatic test_masks();
    blank_mask = 8'h80; dp_mask = 8'h01;
    for (int c = 0; c < FRAME + SLOT; c++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp, select, frame_start} !== {m_an, m_seg, m_dp, m_sel, m_fs}) begin
        n_bad++;
        $display("FAIL masks cyc=%0d got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b",
                 c, an, seg, dp, select, frame_start, m_an, m_seg, m_dp, m_sel, m_fs);
      end
      if (an !== 8'hFF) begin
        n_cmp++;
        if (select == 3'd7 || dp !== (select == 3'd0 ? 1'b0 : 1'b1)) begin
          n_bad++;
          $display("FAIL mask_dp sel=%0d got an=%h dp=%b", select, an, dp);
        end
      end
    end
    blank_mask = 0; dp_mask = 0;
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    while (!(m_sel == 3'd4 && m_an != 8'hFF) && k < 200) begin tick(); k++; end
    n_cmp++;
    if (k >= 200) begin
      n_bad++;
      $display("FAIL reset_mid_wait got timeout want digit 4 lit");
    end
    tick();
    #2 reset = 1;
    #1;
    n_cmp++;
    if ({an, select, seg, dp, frame_start} !== {8'hFF, 3'd0, 7'h7F, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async got an=%h sel=%0d seg=%b want an=ff sel=0 seg=1111111", an, select, seg);
    end
    m_off();
    @(negedge clk); reset = 0; enable = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if ({an, seg, dp, select, frame_start} !== {m_an, m_seg, m_dp, m_sel, m_fs}) begin
        n_bad++;
        $display("FAIL reset_restart edge=%0d got %h/%b/%0d want %h/%b/%0d", i, an, seg, select, m_an, m_seg, m_sel);
      end
    end
    n_cmp++;
    if (an !== 8'hFE) begin
      n_bad++;
      $display("FAIL reset_digit0 got an=%h want fe", an);
    end
  endtask

  task automatic test_enable_drop();
    int k;
    k = 0;
    while (!(m_sel != 3'd0 && m_p % SLOT == 0) && k < 200) begin tick(); k++; end
    n_cmp++;
    if (k >= 200) begin
      n_bad++;
      $display("FAIL drop_wait got timeout want mid-blank of digit>0");
    end
    enable = 0;
    tick();
    n_cmp++;
    if ({an, seg, dp, select, frame_start} !== {8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL drop_off got an=%h seg=%b dp=%b sel=%0d want off values", an, seg, dp, select);
    end
    enable = 1;
    for (int i = 1; i <= 3; i++) tick();
    n_cmp++;
    if ({an, select, seg} !== {8'hFE, 3'd0, 7'b0110000}) begin
      n_bad++;
      $display("FAIL drop_restart got an=%h sel=%0d seg=%b want fe/0/0110000", an, select, seg);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1;
      if ($urandom_range(0, 19) == 0) blank_mask = 8'($urandom);
      if ($urandom_range(0, 19) == 0) dp_mask = 8'($urandom);
      if ($urandom_range(0, 29) == 0) word = $urandom;
      tick();
      n_cmp++;
      if ({an, seg, dp, select, frame_start} !== {m_an, m_seg, m_dp, m_sel, m_fs}) begin
        n_bad++;
        $display("FAIL random cyc=%0d got %h/%b/%b/%0d/%b want %h/%b/%b/%0d/%b",
                 c, an, seg, dp, select, frame_start, m_an, m_seg, m_dp, m_sel, m_fs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_digit();
    test_frames();
    test_masks();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
